// File: rtl/blinky.sv
// SPI-to-WS2812 bridge: mode-0 SPI slave -> 4-deep 24-bit FIFO -> cycle-timed WS2812 serialiser.
// Optional heartbeat on uo_out[7] when BLINKY_HEARTBEAT_EN is defined.
module blinky #(
    parameter int T0H     = 8,
    parameter int T1H     = 16,
    parameter int TBIT    = 25,
    parameter int TRESET  = 1000,
    parameter int HB_BITS = 22
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int CMAX = (TRESET > TBIT) ? TRESET : TBIT;
    localparam int CW   = $clog2(CMAX) + 1;
    localparam logic [CW-1:0] T0H_LAST  = CW'(T0H - 1);
    localparam logic [CW-1:0] T1H_LAST  = CW'(T1H - 1);
    localparam logic [CW-1:0] TBIT_LAST = CW'(TBIT - 1);
    localparam logic [CW-1:0] TRST_LAST = CW'(TRESET - 1);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, LATCH} state_t;

    logic unused_ok;
    assign unused_ok = &{1'b0, ena, uio_in, ui_in[7:3]};

    logic [1:0] sck_sync, mosi_sync, csn_sync;
    logic       sck_prev;
    logic       sck_rise, cs_active;

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync  <= '0;
            mosi_sync <= '0;
            csn_sync  <= '0;
            sck_prev  <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[0], ui_in[0]};
            mosi_sync <= {mosi_sync[0], ui_in[1]};
            csn_sync  <= {csn_sync[0], ui_in[2]};
            sck_prev  <= sck_sync[1];
        end
    end

    assign sck_rise  = sck_sync[1] & ~sck_prev;
    assign cs_active = ~csn_sync[1];

    logic [23:0] shreg;
    logic [4:0]  bit_cnt;
    logic        wr_req;
    logic [23:0] wr_data;

    // The 24th bit is merged combinationally so the word lands in the FIFO on the same edge.
    assign wr_data = {shreg[22:0], mosi_sync[1]};
    assign wr_req  = sck_rise && cs_active && (bit_cnt == 5'd23);

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (!cs_active) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (sck_rise) begin
            shreg   <= wr_data;
            bit_cnt <= (bit_cnt == 5'd23) ? 5'd0 : bit_cnt + 5'd1;
        end
    end

    logic [23:0] mem [4];
    logic [1:0]  rd_ptr, wr_ptr;
    logic [2:0]  count;
    logic        overflow;
    logic        empty, full, pop, wr_ok;

    assign empty = (count == 3'd0);
    assign full  = count[2];
    // A pop in the same cycle frees the slot, so a write while full still lands.
    assign wr_ok = wr_req && (!full || pop);

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 2'd1;
            if (pop)   rd_ptr <= rd_ptr + 2'd1;
            count    <= count + 3'(wr_ok) - 3'(pop);
            overflow <= overflow | (wr_req & ~wr_ok);
        end
    end

    state_t        state;
    logic [CW-1:0] cnt;
    logic [4:0]    bit_idx;
    logic [23:0]   word;
    logic          dout;
    logic [CW-1:0] hi_last;

    assign hi_last = word[bit_idx] ? T1H_LAST : T0H_LAST;
    assign pop = !empty && ((state == IDLE) ||
                            (state == LOW && cnt == TBIT_LAST && bit_idx == 5'd0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            word    <= '0;
            dout    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    dout <= 1'b0;
                    cnt  <= '0;
                    if (pop) begin
                        word    <= mem[rd_ptr];
                        bit_idx <= 5'd23;
                        dout    <= 1'b1;
                        state   <= HIGH;
                    end
                end
                HIGH: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == hi_last) begin
                        dout  <= 1'b0;
                        state <= LOW;
                    end
                end
                LOW: begin
                    if (cnt == TBIT_LAST) begin
                        cnt <= '0;
                        if (bit_idx != 5'd0) begin
                            bit_idx <= bit_idx - 5'd1;
                            dout    <= 1'b1;
                            state   <= HIGH;
                        end else if (pop) begin
                            word    <= mem[rd_ptr];
                            bit_idx <= 5'd23;
                            dout    <= 1'b1;
                            state   <= HIGH;
                        end else begin
                            state <= LATCH;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LATCH: begin
                    if (cnt == TRST_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic busy, hb;
    assign busy = (state != IDLE) || !empty;

`ifdef BLINKY_HEARTBEAT_EN
    logic [HB_BITS-1:0] hb_cnt;
    always_ff @(posedge clk) begin
        if (rst) hb_cnt <= '0;
        else     hb_cnt <= hb_cnt + 1'b1;
    end
    assign hb = hb_cnt[HB_BITS-1];
`else
    logic [HB_BITS-1:0] unused_hb;
    assign unused_hb = '0;
    assign hb        = 1'b0;
`endif

    assign uo_out  = {hb, 3'b000, overflow, full, busy, dout};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_blinky.sv
// Scoreboard bench for blinky: SPI words are queued as expected, a monitor decodes the WS2812 line.
module tb_blinky;
    localparam int TBIT = 25, TRESET = 1000, HB = 4;

    logic       clk = 1'b0, rst = 1'b1, ena = 1'b1;
    logic [7:0] ui_in = 8'h04, uio_in = 8'h00;
    logic [7:0] uo_out, uio_out, uio_oe;

    always #5 clk = ~clk;

    blinky #(.T0H(8), .T1H(16), .TBIT(TBIT), .TRESET(TRESET), .HB_BITS(HB)) dut (
        .clk(clk), .rst(rst), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    wire dout = uo_out[0];
    wire busy = uo_out[1];
    wire ffull = uo_out[2];
    wire ovf = uo_out[3];

    int checks = 0, failures = 0;
    logic [23:0] sb[$];

    int hi_len = 0, since_rise = 100000, bit_n = 0, rise_cnt = 0, words_seen = 0, hb_bad = 0;
    logic [23:0] acc = '0, exp_w;
    logic prev_dout = 1'b0, prev_busy = 1'b0, full_seen = 1'b0;
    logic [HB-1:0] tb_hb = '0;

    always @(posedge clk) begin
        if (rst) tb_hb <= '0;
        else     tb_hb <= tb_hb + 1'b1;
    end

    // Monitor: decode pulses into bits/words and compare against the scoreboard.
    always @(negedge clk) begin
`ifdef BLINKY_HEARTBEAT_EN
        if (uo_out[7] !== tb_hb[HB-1]) hb_bad++;
`else
        if (uo_out[7] !== 1'b0) hb_bad++;
`endif
        if (rst) begin
            hi_len = 0; since_rise = 100000; bit_n = 0; acc = '0;
            prev_dout = 1'b0; prev_busy = 1'b0;
        end else begin
            if (ffull) full_seen = 1'b1;
            if (dout && !prev_dout) begin
                rise_cnt++;
                if (since_rise + 1 < TRESET) begin
                    checks++;
                    if (since_rise + 1 != TBIT) begin
                        failures++;
                        $display("FAIL bit_period got=%0d exp=%0d", since_rise + 1, TBIT);
                    end
                end
                since_rise = 0;
                hi_len = 1;
            end else begin
                since_rise++;
                if (dout) hi_len++;
            end
            if (!dout && prev_dout) begin
                checks++;
                if (hi_len == 16) acc = {acc[22:0], 1'b1};
                else if (hi_len == 8) acc = {acc[22:0], 1'b0};
                else begin
                    failures++;
                    $display("FAIL high_width got=%0d exp=8_or_16", hi_len);
                    acc = {acc[22:0], 1'b0};
                end
                bit_n++;
                if (bit_n == 24) begin
                    bit_n = 0;
                    words_seen++;
                    checks++;
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_word got=%06h exp=none", acc);
                    end else begin
                        exp_w = sb.pop_front();
                        if (acc !== exp_w) begin
                            failures++;
                            $display("FAIL word got=%06h exp=%06h", acc, exp_w);
                        end
                    end
                end
            end
            if (!busy && prev_busy) begin
                checks++;
                if (since_rise != TBIT + TRESET) begin
                    failures++;
                    $display("FAIL latch_gap got=%0d exp=%0d", since_rise, TBIT + TRESET);
                end
            end
            prev_dout = dout;
            prev_busy = busy;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_bits(input logic [23:0] w, input int n);
        for (int i = 23; i > 23 - n; i--) begin
            ui_in[1] = w[i];
            ui_in[0] = 1'b0;
            tick(2);
            ui_in[0] = 1'b1;
            tick(2);
        end
        ui_in[0] = 1'b0;
    endtask

    task automatic cs(input logic v);
        ui_in[2] = v;
        tick(4);
    endtask

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        tick(10);
        while (busy && n < 20000) begin
            tick(1);
            n++;
        end
        check({name, "_idle_timeout"}, int'(busy), 0);
        check({name, "_sb_drained"}, sb.size(), 0);
    endtask

    initial begin
        int r0, n;
        // Reset values
        tick(2);
        @(negedge clk);
        check("rst_uo_out", int'(uo_out), 0);
        check("rst_uio_oe", int'(uio_oe), 0);
        check("rst_uio_out", int'(uio_out), 0);
        check("rst_busy", int'(busy), 0);
        tick(1);
        rst = 1'b0;
        tick(4);

        // Single word 0xFF0000
        sb.push_back(24'hFF0000);
        cs(1'b0);
        spi_bits(24'hFF0000, 24);
        cs(1'b1);
        wait_idle("one_word");
        check("one_word_ovf", int'(ovf), 0);

        // Full word plus 5 trailing bits; partial word discarded on CS_N high
        sb.push_back(24'hA5A5A5);
        cs(1'b0);
        spi_bits(24'hA5A5A5, 24);
        spi_bits(24'hF80000, 5);
        cs(1'b1);
        wait_idle("partial");
        check("partial_ovf", int'(ovf), 0);

        // Six words in one frame: five back-to-back, the sixth overflows
        full_seen = 1'b0;
        sb.push_back(24'h123456);
        sb.push_back(24'h00FF00);
        sb.push_back(24'h800001);
        sb.push_back(24'h5A5A5A);
        sb.push_back(24'hC3C33C);
        cs(1'b0);
        spi_bits(24'h123456, 24);
        spi_bits(24'h00FF00, 24);
        spi_bits(24'h800001, 24);
        spi_bits(24'h5A5A5A, 24);
        spi_bits(24'hC3C33C, 24);
        spi_bits(24'h0F0F0F, 24);
        cs(1'b1);
        wait_idle("burst");
        check("burst_ovf", int'(ovf), 1);
        check("burst_full_seen", int'(full_seen), 1);
        check("burst_full_clear", int'(ffull), 0);

        // Reset during bit 10 of a transmission
        sb.push_back(24'h3CA5F0);
        cs(1'b0);
        spi_bits(24'h3CA5F0, 24);
        cs(1'b1);
        n = 0;
        while (bit_n != 10 && n < 5000) begin
            tick(1);
            n++;
        end
        check("midtx_reach_bit10", bit_n, 10);
        tick(3);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midtx_dout", int'(dout), 0);
        check("midtx_busy", int'(busy), 0);
        check("midtx_ovf", int'(ovf), 0);
        tick(1);
        rst = 1'b0;
        sb.delete();
        r0 = rise_cnt;
        tick(2000);
        check("midtx_no_more_tx", rise_cnt - r0, 0);
        check("midtx_still_idle", int'(busy), 0);

        check("heartbeat_mismatches", hb_bad, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/blinky.md
# blinky

SPI-to-WS2812 bridge. It receives 24-bit GRB colour words over a mode-0 SPI slave port on the dedicated inputs. Received words are buffered in a 4-entry FIFO and serialised onto a single WS2812 data line using cycle-counted pulse widths. It is the top-level user block of the chip, with the standard 8-in / 8-out / 8-bidir pin set.

## Interface
- `T0H`, default 8: high-time cycles of a 0 bit.
- `T1H`, default 16: high-time cycles of a 1 bit.
- `TBIT`, default 25: total cycles per bit. At 20 MHz this gives 0.4 / 0.8 / 1.25 µs.
- `TRESET`, default 1000: low-time cycles of the latch/reset gap (50 µs at 20 MHz).
- `HB_BITS`, default 22: heartbeat divider width.

Ports:
- `clk`  in  1: single system clock; all logic on its rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `ena`  in  1: design-selected indication; ignored.
- `ui_in`  in  8:
  - [0] SCK
  - [1] MOSI
  - [2] CS_N
  - [7:3] unused
- `uio_in`  in  8: unused.
- `uo_out`  out  8:
  - [0] WS2812 DOUT
  - [1] BUSY
  - [2] FIFO_FULL
  - [3] OVERFLOW (sticky)
  - [6:4] 0
  - [7] HEARTBEAT
- `uio_out`  out  8: constant 0.
- `uio_oe`  out  8: constant 0 (all bidirs are inputs).

## Operation
- **Input synchronisation.** SCK, MOSI and CS_N each pass through a 2-FF synchroniser. A rising SCK edge is detected on the synchronised signal. SCK must not exceed clk/4.
- **SPI receive, mode 0, MSB first.**
  - On each detected rising SCK edge while CS_N is low, MOSI shifts into a 24-bit shift register and the bit counter increments.
  - When the 24th bit arrives, the word is written to the FIFO and the bit counter clears. Further words may follow in the same CS_N frame.
  - CS_N high clears the bit counter and discards any partial word.
  - SCK edges while CS_N is high are ignored.
- **FIFO.**
  - 4 entries × 24 bits, with 2-bit read/write pointers that wrap 3→0.
  - FIFO_FULL is high when the count is 4.
  - A write while full is dropped and sets OVERFLOW. OVERFLOW clears only on `rst`.
  - A simultaneous write and pop while full is accepted: the pop frees a slot the same cycle.
- **Transmitter FSM**, states IDLE, HIGH, LOW, LATCH:
  - IDLE: DOUT=0. If the FIFO is non-empty, pop a word, set bit index to 23, go to HIGH.
  - HIGH: DOUT=1 for T0H or T1H cycles, according to the current bit. Then go to LOW.
  - LOW: DOUT=0 until the bit total reaches TBIT cycles. Then:
    - If the bit index is >0, decrement it and go to HIGH.
    - Otherwise, if the FIFO is non-empty, pop the next word and go to HIGH with no gap.
    - Otherwise go to LATCH.
  - LATCH: DOUT=0 for TRESET cycles, then go to IDLE.
- **BUSY** = (state ≠ IDLE) or (FIFO non-empty).
- **Reset.** `rst` mid-frame or mid-bit forces IDLE, DOUT=0, empties the FIFO, clears the shift register, bit counter and OVERFLOW, and zeroes the synchroniser flops.

## Timing
- Reset values:
  - `uo_out` = 0x00.
  - `uio_out` = 0x00, `uio_oe` = 0x00.
  - FSM in IDLE.
  - Heartbeat counter = 0.
- SPI latency: the FIFO write occurs 3 clk after the 24th raw SCK rising edge (2 sync + 1 edge detect). The FIFO count is visible the following cycle.
- TX latency:
  - Cycle N: word written.
  - Cycle N+1: FIFO non-empty; IDLE pops.
  - Cycle N+2: DOUT high.
- Bit period is exactly TBIT clk. Consecutive words are back-to-back.
- Minimum DOUT-low time before the next IDLE pop is TRESET cycles.
- FIFO_FULL and OVERFLOW are registered and update the cycle after the causing write.

## Configuration
- Macro `BLINKY_HEARTBEAT_EN`.
- Defined:
  - A free-running HB_BITS-wide counter increments every clk.
  - `uo_out[7]` = counter MSB, giving a 50 % duty square wave of period 2^HB_BITS clk.
  - The counter resets to 0.
- Undefined: the counter is not instantiated and `uo_out[7]` is tied to 0.

## Test plan
- Reset: assert `rst` 2 cycles → `uo_out`=0x00, `uio_oe`=0x00, BUSY=0.
- Send one SPI word 0xFF0000 (CS_N low, 24 SCK pulses, CS_N high):
  - DOUT shows 8 pulses of 16-cycle high, then 16 pulses of 8-cycle high, each bit 25 cycles.
  - Then 1000 low cycles, then BUSY=0.
- Send 24 bits 0xA5A5A5 then 5 extra bits, then raise CS_N → exactly one word transmitted; the partial word is discarded.
- Send 6 words in one CS_N frame at clk/4 SCK → words 1–5 transmitted back-to-back with no gap; the final word is dropped with OVERFLOW=1 and FIFO_FULL seen high.
- Assert `rst` during bit 10 of a transmission → DOUT=0 next cycle, BUSY=0, OVERFLOW=0, nothing further transmitted.
- With `BLINKY_HEARTBEAT_EN` defined and HB_BITS=4 → `uo_out[7]` toggles every 8 clk after reset. Undefined → `uo_out[7]` stays 0.
